// File: rtl/header_strip.sv
// H2C header stripper: drops DummyHeader slots, forwards real headers, the
// length word and payload, and regenerates TLAST. Option: HEADER_STRIP_TLAST_CHECK_EN.
module header_strip #(
    parameter int          HeaderMax   = 10,
    parameter logic [63:0] DummyHeader = {8'h01, 56'h0}
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    input  logic [63:0] S_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    output logic [63:0] M_AXIS_TDATA,
    output logic [15:0] PKT_CNT,
    output logic        ERR_SHORT
);

    typedef enum logic [2:0] {
        HDR = 3'b001,
        LEN = 3'b010,
        PAY = 3'b100
    } state_e;

    localparam logic [15:0] SlotLast = 16'(HeaderMax - 1);

    state_e      state_q, state_d;
    logic [15:0] slot_q, slot_d;
    logic [31:0] togo_q, togo_d;
    logic [15:0] pkt_q, pkt_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic        last_q, last_d;

    logic        hs;
    logic        is_hdr;
    logic        is_dummy;
    logic [31:0] len_w;
    logic        fwd;
    logic        gen_last;
    logic        out_last;
    logic        err_set;

    assign S_AXIS_TREADY = ~valid_q | M_AXIS_TREADY;
    assign hs            = S_AXIS_TVALID & S_AXIS_TREADY;
    assign is_hdr        = S_AXIS_TDATA[63:56] == 8'h01;
    assign is_dummy      = S_AXIS_TDATA == DummyHeader;
    assign len_w         = S_AXIS_TDATA[31:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HDR;
            slot_q  <= '0;
            togo_q  <= '0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            togo_q  <= togo_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // A non-header word in HDR is taken as an early length word.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        togo_d  = togo_q;
        if (hs) begin
            unique case (1'b1)
                state_q[0]: begin
                    if (is_hdr) begin
                        if (slot_q == SlotLast) begin
                            state_d = LEN;
                            slot_d  = '0;
                        end else begin
                            slot_d = slot_q + 16'd1;
                        end
                    end else begin
                        slot_d  = '0;
                        togo_d  = len_w;
                        state_d = (len_w == 32'd0) ? HDR : PAY;
                    end
                end
                state_q[1]: begin
                    togo_d  = len_w;
                    state_d = (len_w == 32'd0) ? HDR : PAY;
                end
                state_q[2]: begin
                    togo_d = togo_q - 32'd1;
                    if (togo_q == 32'd1) begin
                        state_d = HDR;
                    end
                end
                default: begin
                    state_d = HDR;
                end
            endcase
        end
    end

    always_comb begin
        gen_last = 1'b0;
        unique case (1'b1)
            state_q[0]: gen_last = ~is_hdr & (len_w == 32'd0);
            state_q[1]: gen_last = len_w == 32'd0;
            state_q[2]: gen_last = togo_q == 32'd1;
            default:    gen_last = 1'b0;
        endcase

        fwd     = hs & ~(state_q[0] & is_dummy);
        err_set = hs & state_q[0] & ~is_hdr;
`ifdef HEADER_STRIP_TLAST_CHECK_EN
        out_last = gen_last & S_AXIS_TLAST;
        err_set  = err_set | (hs & S_AXIS_TLAST & ~gen_last);
`else
        out_last = gen_last;
`endif

        pkt_d   = (hs & gen_last) ? pkt_q + 16'd1 : pkt_q;
        err_d   = err_q | err_set;
        valid_d = fwd | (valid_q & ~M_AXIS_TREADY);
        data_d  = fwd ? S_AXIS_TDATA : data_q;
        last_d  = fwd ? out_last : last_q;
    end

`ifndef HEADER_STRIP_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = S_AXIS_TLAST;
`endif

    assign M_AXIS_TVALID = valid_q;
    assign M_AXIS_TDATA  = data_q;
    assign M_AXIS_TLAST  = last_q;
    assign PKT_CNT       = pkt_q;
    assign ERR_SHORT     = err_q;

endmodule

// File: tb/tb_header_strip.sv
// Bench for header_strip: packet table, reset and wrap sequences, and a
// randomized run checked against a packet-level reference model.
module tb_header_strip;

    localparam logic [63:0] DUMMY = {8'h01, 56'h0};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST = 1'b0;
    logic [63:0] S_AXIS_TDATA = '0;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        M_AXIS_TLAST;
    logic [63:0] M_AXIS_TDATA;
    logic [15:0] PKT_CNT;
    logic        ERR_SHORT;

    header_strip dut (
        .CLK           (CLK),
        .RST           (RST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .PKT_CNT       (PKT_CNT),
        .ERR_SHORT     (ERR_SHORT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int nslots;
        int nreal;
        int len;
        int exp_words;
        bit exp_err;
    } vec_t;

    vec_t        tbl[6];
    logic [64:0] in_q[$];
    logic [64:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          nout = 0;
    int          pkt_model = 0;
    bit          mon_en = 1'b1;
    bit          rand_rdy = 1'b0;
    bit          rand_vld = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic        stall = 1'b0;
        logic [64:0] held = '0;
        logic [64:0] e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stable", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA},
                        {1'b1, held});
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    nout++;
                    if (mon_en) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_word: got %0h expected none",
                                     M_AXIS_TDATA);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_word", {M_AXIS_TLAST, M_AXIS_TDATA}, e);
                        end
                    end
                end
                stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                held  = {M_AXIS_TLAST, M_AXIS_TDATA};
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(posedge CLK);
            #1;
            if (rand_rdy) M_AXIS_TREADY = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        S_AXIS_TVALID = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        in_q.delete();
        exp_q.delete();
        pkt_model = 0;
    endtask

    // Model: real headers pass, dummies vanish, length word and payload
    // pass, TLAST on the last word of the packet.
    task automatic build_pkt(input int nslots, input int nreal,
                             input int len, input bit mix);
        logic [63:0] w;
        bit          is_real;
        for (int s = 0; s < nslots; s++) begin
            is_real = mix ? ($urandom_range(0, 1) == 1) : (s < nreal);
            if (is_real) begin
                w = {8'h01, (mix ? 24'($urandom) : 24'h0), 32'(s + 2)};
                in_q.push_back({1'b0, w});
                exp_q.push_back({1'b0, w});
            end else begin
                in_q.push_back({1'b0, DUMMY});
            end
        end
        w = {8'h4C, 24'(pkt_model), 32'(len)};
        in_q.push_back({len == 0, w});
        exp_q.push_back({len == 0, w});
        for (int p = 0; p < len; p++) begin
            w = {$urandom, $urandom};
            in_q.push_back({p == len - 1, w});
            exp_q.push_back({p == len - 1, w});
        end
        pkt_model++;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l,
                             output int cyc);
        logic hs;
        cyc = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        do begin
            @(negedge CLK);
            hs = S_AXIS_TREADY;
            @(posedge CLK);
            #1;
            cyc++;
        end while (!hs && cyc < 5000);
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no ready expected ready");
        end
        S_AXIS_TVALID = 1'b0;
        if (rand_vld && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic send_n(input int n, output int cyc);
        logic [64:0] e;
        int          c;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            e = in_q.pop_front();
            send_word(e[63:0], e[64], c);
            cyc += c;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || M_AXIS_TVALID) && k < 20000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("drain", {exp_q.size(), 31'd0, M_AXIS_TVALID}, 128'd0);
    endtask

    int cyc;
    int nin;
    int n0;
    int len;

    initial begin
        tbl[0] = '{10, 2, 4, 7, 1'b0};
        tbl[1] = '{10, 0, 0, 1, 1'b0};
        tbl[2] = '{10, 10, 1, 12, 1'b0};
        tbl[3] = '{10, 3, 0, 4, 1'b0};
        tbl[4] = '{3, 1, 2, 4, 1'b1};
        tbl[5] = '{10, 2, 3, 6, 1'b1};

        fork
            monitor();
            rdy_gen();
        join_none

        do_reset();
        chk("rst_valid", M_AXIS_TVALID, 0);
        chk("rst_last", M_AXIS_TLAST, 0);
        chk("rst_data", M_AXIS_TDATA, 0);
        chk("rst_pkt", PKT_CNT, 0);
        chk("rst_err", ERR_SHORT, 0);
        chk("rst_ready", S_AXIS_TREADY, 1);

        for (int i = 0; i < 6; i++) begin
            n0 = nout;
            build_pkt(tbl[i].nslots, tbl[i].nreal, tbl[i].len, 1'b0);
            nin = in_q.size();
            send_n(nin, cyc);
            wait_drain();
            chk("row_words", 128'(nout - n0), 128'(tbl[i].exp_words));
            chk("row_cycles", 128'(cyc), 128'(nin));
            chk("row_pkt", PKT_CNT, 128'(i + 1));
            chk("row_err", ERR_SHORT, tbl[i].exp_err);
        end

        // Reset just after the length word of a 37-word payload.
        do_reset();
        build_pkt(10, 0, 37, 1'b0);
        send_n(11, cyc);
        do_reset();
        chk("midrst_valid", M_AXIS_TVALID, 0);
        chk("midrst_pkt", PKT_CNT, 0);
        chk("midrst_err", ERR_SHORT, 0);
        build_pkt(10, 1, 5, 1'b0);
        send_n(in_q.size() - 1, cyc);
        chk("postrst_pkt_open", PKT_CNT, 0);
        send_n(1, cyc);
        wait_drain();
        chk("postrst_pkt", PKT_CNT, 1);
        chk("postrst_err", ERR_SHORT, 0);

        rand_rdy = 1'b1;
        rand_vld = 1'b1;
        for (int k = 0; k < 50; k++) begin
            len = (k % 5 == 0) ? int'($urandom_range(1, 200))
                               : int'($urandom_range(1, 40));
            build_pkt(10, 0, len, 1'b1);
            send_n(in_q.size(), cyc);
        end
        wait_drain();
        chk("rand_pkt", PKT_CNT, 128'(16'(pkt_model)));
        chk("rand_err", ERR_SHORT, 0);
        rand_rdy = 1'b0;
        rand_vld = 1'b0;
        M_AXIS_TREADY = 1'b1;

        // One-word packets: early length word of zero, one per cycle.
        do_reset();
        mon_en = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b1;
        S_AXIS_TVALID = 1'b1;
        repeat (65535) @(posedge CLK);
        #1;
        chk("wrap_ffff", PKT_CNT, 16'hFFFF);
        @(posedge CLK);
        #1;
        S_AXIS_TVALID = 1'b0;
        chk("wrap_zero", PKT_CNT, 0);
        chk("wrap_err", ERR_SHORT, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
